// File: rtl/gmii_video_pkg.sv
// Shared layout of the 29-bit video FIFO word between the GMII receive parser
// and the line-buffer writer.
package gmii_video_pkg;

    localparam int VW_W          = 29;
    localparam int VW_RSV        = 28;
    localparam int VW_X          = 27;
    localparam int VW_Y_HI       = 26;
    localparam int VW_Y_LO       = 16;
    localparam int VW_D_HI       = 15;
    localparam int VW_D_LO       = 0;

    localparam int Y_W           = 11;
    localparam int WORDS_PER_SEG = 600;

    function automatic logic [VW_W-1:0] vw_pack(input logic rsv, input logic x,
                                                input logic [Y_W-1:0] y,
                                                input logic [15:0] d);
        return {rsv, x, y, d};
    endfunction

endpackage

// File: rtl/fifo2linebuf_seg.sv
// Segment tracker: decides write/discard for each popped word, computes the
// line-RAM address and tracks which halves of the current line are complete.
module fifo2linebuf_seg
    import gmii_video_pkg::*;
#(
    parameter int WORDS_PER_SEG = gmii_video_pkg::WORDS_PER_SEG,
    parameter int ADDR_W        = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic              rsv_i,
    input  logic              x_i,
    input  logic [Y_W-1:0]    y_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              err_o,
    output logic              done_o
);

    localparam int CNT_W = $clog2(WORDS_PER_SEG + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORDS_PER_SEG);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS_PER_SEG - 1);

    logic             open_q, open_d;
    logic             x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mask_q, mask_d;
    logic [Y_W-1:0]   line_q, line_d;

    logic [CNT_W-1:0] wcnt;
    logic             new_seg;
    logic [1:0]       mask_base;
    logic [1:0]       mask_new;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            open_q <= 1'b0;
            x_q    <= 1'b0;
            y_q    <= '0;
            cnt_q  <= '0;
            mask_q <= 2'b00;
            line_q <= '0;
        end else begin
            open_q <= open_d;
            x_q    <= x_d;
            y_q    <= y_d;
            cnt_q  <= cnt_d;
            mask_q <= mask_d;
            line_q <= line_d;
        end
    end

    always_comb begin
        open_d    = open_q;
        x_d       = x_q;
        y_d       = y_q;
        cnt_d     = cnt_q;
        mask_d    = mask_q;
        line_d    = line_q;
        we_o      = 1'b0;
        err_o     = 1'b0;
        done_o    = 1'b0;
        wcnt      = cnt_q;
        new_seg   = !open_q || (x_i != x_q) || (y_i != y_q);
        mask_base = 2'b00;
        mask_new  = 2'b00;

        // A reserved-bit word is dropped without touching the open segment,
        // so a key change carried by it never also counts as a short segment.
        if (valid_i) begin
            if (rsv_i) begin
                err_o = 1'b1;
            end else if (new_seg) begin
                err_o  = open_q && (cnt_q < CNT_FULL);
                open_d = 1'b1;
                x_d    = x_i;
                y_d    = y_i;
                wcnt   = '0;
                we_o   = 1'b1;
            end else if (cnt_q < CNT_FULL) begin
                we_o = 1'b1;
            end else begin
                err_o = 1'b1;
            end

            if (we_o) begin
                cnt_d = wcnt + 1'b1;
                if (wcnt == CNT_LAST) begin
                    mask_base = (line_q == y_i) ? mask_q : 2'b00;
                    mask_new  = mask_base | (x_i ? 2'b10 : 2'b01);
                    line_d    = y_i;
                    if (mask_new == 2'b11) begin
                        done_o = 1'b1;
                        mask_d = 2'b00;
                    end else begin
                        mask_d = mask_new;
                    end
                end
            end
        end
    end

    assign addr_o = (x_i ? ADDR_W'(WORDS_PER_SEG) : '0) + ADDR_W'(wcnt);

endmodule

// File: rtl/fifo2linebuf.sv
// Video FIFO consumer: pops 29-bit words and writes pixel pairs into the
// banked line-buffer RAM, pulsing line_done when both halves of a line landed.
module fifo2linebuf
    import gmii_video_pkg::*;
#(
    parameter int WORDS_PER_SEG = gmii_video_pkg::WORDS_PER_SEG,
    parameter int ADDR_W        = 11,
    parameter int BANK_W        = 1,
    parameter int ERR_W         = 16
) (
    input  logic              clk125,
    input  logic              sys_rst_n,
    input  logic [VW_W-1:0]   fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic              hold,
    output logic              buf_we,
    output logic [BANK_W-1:0] buf_bank,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [15:0]       buf_wdata,
    output logic              line_done,
    output logic [Y_W-1:0]    line_y,
    output logic [ERR_W-1:0]  err_cnt
);

    logic              en_q;
    logic              rd_q;
    logic              we_q;
    logic [BANK_W-1:0] bank_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic              done_q;
    logic [Y_W-1:0]    done_y_q;
    logic              line_done_q;
    logic [Y_W-1:0]    line_y_q;
    logic [ERR_W-1:0]  err_q;

    logic              seg_we;
    logic [ADDR_W-1:0] seg_addr;
    logic              seg_err;
    logic              seg_done;
    logic [Y_W-1:0]    word_y;

    assign word_y = fifo_dout[VW_Y_HI:VW_Y_LO];

    // en_q keeps pops off until the first clock after reset release.
    assign fifo_rd_en = en_q && !fifo_empty && !hold;

    fifo2linebuf_seg #(
        .WORDS_PER_SEG (WORDS_PER_SEG),
        .ADDR_W        (ADDR_W)
    ) u_seg (
        .clk     (clk125),
        .rst_n   (sys_rst_n),
        .valid_i (rd_q),
        .rsv_i   (fifo_dout[VW_RSV]),
        .x_i     (fifo_dout[VW_X]),
        .y_i     (word_y),
        .we_o    (seg_we),
        .addr_o  (seg_addr),
        .err_o   (seg_err),
        .done_o  (seg_done)
    );

    always_ff @(posedge clk125 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            en_q        <= 1'b0;
            rd_q        <= 1'b0;
            we_q        <= 1'b0;
            bank_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            done_q      <= 1'b0;
            done_y_q    <= '0;
            line_done_q <= 1'b0;
            line_y_q    <= '0;
            err_q       <= '0;
        end else begin
            en_q        <= 1'b1;
            rd_q        <= fifo_rd_en;
            we_q        <= seg_we;
            done_q      <= seg_done;
            line_done_q <= done_q;
            if (seg_we) begin
                bank_q  <= word_y[BANK_W-1:0];
                addr_q  <= seg_addr;
                wdata_q <= fifo_dout[VW_D_HI:VW_D_LO];
            end
            if (seg_done) begin
                done_y_q <= word_y;
            end
            if (done_q) begin
                line_y_q <= done_y_q;
            end
            if (seg_err && (err_q != '1)) begin
                err_q <= err_q + 1'b1;
            end
        end
    end

    assign buf_we    = we_q;
    assign buf_bank  = bank_q;
    assign buf_addr  = addr_q;
    assign buf_wdata = wdata_q;
    assign line_done = line_done_q;
    assign line_y    = line_y_q;
    assign err_cnt   = err_q;

endmodule

// File: tb/tb_fifo2linebuf.sv
// Scoreboard bench for fifo2linebuf: a queue-backed FIFO model feeds the DUT,
// expected writes and line completions are queued as words are issued.
module tb_fifo2linebuf;
    import gmii_video_pkg::*;

    localparam int WPS = 600;

    logic        clk125 = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [28:0] fifo_dout = '0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic        hold = 1'b0;
    logic        buf_we;
    logic [0:0]  buf_bank;
    logic [10:0] buf_addr;
    logic [15:0] buf_wdata;
    logic        line_done;
    logic [10:0] line_y;
    logic [15:0] err_cnt;

    fifo2linebuf dut (
        .clk125     (clk125),
        .sys_rst_n  (sys_rst_n),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .hold       (hold),
        .buf_we     (buf_we),
        .buf_bank   (buf_bank),
        .buf_addr   (buf_addr),
        .buf_wdata  (buf_wdata),
        .line_done  (line_done),
        .line_y     (line_y),
        .err_cnt    (err_cnt)
    );

    always #4 clk125 = ~clk125;

    typedef struct packed {
        logic [10:0] addr;
        logic        bank;
        logic [15:0] data;
    } wr_t;

    logic [28:0] fq[$];
    wr_t         exp_wr[$];
    int          exp_done[$];
    int          checks = 0;
    int          failures = 0;
    int          exp_err = 0;
    int          rd_viol = 0;
    bit          gap_en = 0;
    bit          hold_en = 0;
    logic        prev_we = 1'b0;
    logic [10:0] prev_addr = '0;
    wr_t         e;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Source side: empty/hold for the coming cycle, optionally randomised.
    initial begin
        forever begin
            @(negedge clk125);
            fifo_empty = (fq.size() == 0) || (gap_en && ($urandom_range(0, 2) == 0));
            hold       = hold_en && ($urandom_range(0, 3) == 0);
        end
    end

    always @(posedge clk125) begin
        if (fifo_rd_en) begin
            if (fifo_empty || hold || fq.size() == 0) rd_viol++;
            else fifo_dout <= fq.pop_front();
        end
    end

    always @(negedge clk125) begin
        if (buf_we) begin
            if (exp_wr.size() == 0) begin
                chk("unexpected_write_addr", longint'(buf_addr), -1);
            end else begin
                e = exp_wr.pop_front();
                chk("wr_addr", buf_addr, e.addr);
                chk("wr_bank", buf_bank, e.bank);
                chk("wr_data", buf_wdata, e.data);
            end
        end
        if (line_done) begin
            if (exp_done.size() == 0) begin
                chk("unexpected_line_done_y", line_y, -1);
            end else begin
                chk("line_y", line_y, exp_done.pop_front());
                chk("done_after_last_write",
                    longint'(prev_we && (prev_addr == 11'd599 || prev_addr == 11'd1199)), 1);
            end
        end
        prev_we   <= buf_we;
        prev_addr <= buf_addr;
    end

    task automatic send_seg(input bit x, input int y, input int n, input int d0,
                            input int start);
        logic [15:0] d;
        for (int i = 0; i < n; i++) begin
            d = 16'(d0 + i);
            fq.push_back(vw_pack(1'b0, x, 11'(y), d));
            if (start + i < WPS)
                exp_wr.push_back('{addr: 11'((x ? WPS : 0) + start + i), bank: 1'(y), data: d});
        end
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((fq.size() != 0 || exp_wr.size() != 0 || exp_done.size() != 0) && t < 20000) begin
            @(negedge clk125);
            t++;
        end
        repeat (6) @(negedge clk125);
        chk({name, "_drain_in_time"}, longint'(t < 20000), 1);
        chk({name, "_err_cnt"}, err_cnt, exp_err);
        chk({name, "_left_writes"}, exp_wr.size(), 0);
        chk({name, "_left_done"}, exp_done.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_we"}, buf_we, 0);
        chk({name, "_addr"}, buf_addr, 0);
        chk({name, "_bank_wdata"}, {buf_bank, buf_wdata}, 0);
        chk({name, "_done_y"}, {line_done, line_y}, 0);
        chk({name, "_err"}, err_cnt, 0);
        chk({name, "_rd_en"}, fifo_rd_en, 0);
    endtask

    initial begin
        int t;
        repeat (3) @(negedge clk125);
        chk_reset_outputs("reset");
        sys_rst_n = 1'b1;
        repeat (2) @(negedge clk125);

        // Full line y=5
        send_seg(1'b0, 5, WPS, 16'h5000, 0);
        send_seg(1'b1, 5, WPS, 16'h5400, 0);
        exp_done.push_back(5);
        drain("line5");

        // Short half then full other half, then completion of y=6
        send_seg(1'b0, 6, 300, 16'h6000, 0);
        send_seg(1'b1, 6, WPS, 16'h6400, 0);
        exp_err = 1;
        drain("short6");
        send_seg(1'b0, 6, WPS, 16'h6800, 0);
        exp_done.push_back(6);
        drain("line6");

        // Overlong segment: 601st word dropped
        send_seg(1'b0, 7, WPS + 1, 16'h7000, 0);
        exp_err = 2;
        drain("long7");

        // Random gaps and backpressure across line y=8
        gap_en  = 1;
        hold_en = 1;
        send_seg(1'b0, 8, WPS, 16'h8000, 0);
        send_seg(1'b1, 8, WPS, 16'h8400, 0);
        exp_done.push_back(8);
        drain("line8_gaps");
        gap_en  = 0;
        hold_en = 0;
        chk("rd_en_while_empty_or_hold", rd_viol, 0);

        // Reserved-bit word in the middle of a segment
        send_seg(1'b0, 10, 300, 16'hA000, 0);
        fq.push_back(vw_pack(1'b1, 1'b0, 11'd10, 16'hDEAD));
        send_seg(1'b0, 10, 300, 16'hA000 + 300, 300);
        send_seg(1'b1, 10, WPS, 16'hA400, 0);
        exp_err = 3;
        exp_done.push_back(10);
        drain("rsv10");

        // Reset in the middle of a segment with pops in flight
        send_seg(1'b0, 9, 200, 16'h9000, 0);
        t = 0;
        while (!(buf_we && buf_addr == 11'd197) && t < 2000) begin
            @(negedge clk125);
            t++;
        end
        chk("reach_addr_197", longint'(t < 2000), 1);
        sys_rst_n = 1'b0;
        fq.delete();
        #1;
        exp_wr.delete();
        exp_err = 0;
        chk_reset_outputs("mid_reset");
        repeat (4) begin
            @(negedge clk125);
            chk("in_reset_we", buf_we, 0);
        end
        chk_reset_outputs("end_reset");
        sys_rst_n = 1'b1;
        send_seg(1'b0, 9, WPS, 16'h9400, 0);
        send_seg(1'b1, 9, WPS, 16'h9800, 0);
        exp_done.push_back(9);
        drain("line9_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo2linebuf.md
Name: fifo2linebuf

Overview:
- Consumer stage on the video FIFO, the FIFO that the GMII receive parser fills with 29-bit words via datain/recv_en.
- Pops words and writes the 16-bit YUV pixel pairs into a banked line-buffer RAM at the address implied by line number and line half.
- Tracks per-line completion so the HDMI output side can see when a line is fully present.
- Flags and counts short, overlong and malformed segments.

Parameters:
- WORDS_PER_SEG, 600: pixel-pair words per received packet (one line half).
- ADDR_W, 11: line-buffer word address width; must hold 2*WORDS_PER_SEG-1.
- BANK_W, 1: line-buffer bank select width; bank = y[BANK_W-1:0].
- ERR_W, 16: error counter width.

Ports:
- clk125  in  1  system clock; the FIFO read side and the line-RAM write port run on it.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- fifo_dout  in  29  FIFO word: [28] reserved (0), [27] x half, [26:16] y line, [15:0] pixel pair.
- fifo_empty  in  1  FIFO empty.
- fifo_rd_en  out  1  FIFO pop; standard FIFO, data valid 1 cycle after pop.
- hold  in  1  downstream backpressure; no new pops while high.
- buf_we  out  1  line-RAM write strobe.
- buf_bank  out  BANK_W  line-RAM bank.
- buf_addr  out  ADDR_W  line-RAM word address.
- buf_wdata  out  16  pixel pair.
- line_done  out  1  one-cycle pulse: both halves of a line written completely.
- line_y  out  11  line number qualified by line_done.
- err_cnt  out  ERR_W  saturating count of error events.

Behaviour:
- Reset (async on sys_rst_n low, released synchronously):
  - All outputs 0, err_cnt 0.
  - Segment state invalid, half-done mask 00.
  - Any in-flight pop is discarded.
- Pop rule:
  - fifo_rd_en = !fifo_empty && !hold.
  - Never pop when empty. hold only stops new pops; the word already popped is still processed.
- Pipeline:
  - Cycle N: pop.
  - Cycle N+1: word valid (rd_q); classify it.
  - Cycle N+2: registered buf_we/addr/data.
  - Throughput: 1 word/cycle.
- Classification of a valid word, with key = {x, y}:
  - bit28 = 1: discard; err_cnt+1.
  - Key differs from the current key, or no segment is open:
    - If a segment is open and cnt < WORDS_PER_SEG, count a short segment (err_cnt+1).
    - Open a new segment, cnt = 0, and write this word.
  - Same key and cnt < WORDS_PER_SEG: write the word.
  - Same key and cnt == WORDS_PER_SEG: overlong; discard and err_cnt+1 (once per extra word).
- Write fields:
  - buf_addr = x*WORDS_PER_SEG + cnt.
  - buf_bank = y[BANK_W-1:0].
  - buf_wdata = word[15:0].
  - cnt increments after each write.
- Completion:
  - The write with cnt == WORDS_PER_SEG-1 sets mask[x] for line y.
  - If the segment's y differs from the tracked line, the mask is cleared before being set (a partial line is abandoned silently).
  - When the mask becomes 11, line_done pulses one cycle after that final write, with line_y = y. The mask is then cleared.
  - A repeated half (mask[x] already 1) is rewritten and does not cause an extra pulse.
- Simultaneous events:
  - Short-segment detection and bit28 discard on the same word count once.
  - err_cnt saturates at all-ones.
- No timeout: a segment stays open across FIFO-empty gaps of any length.

Decomposition:
- Shared package (gmii_video_pkg) holds:
  - Field positions of the 29-bit video FIFO word (bit 28 reserved, 27 x half, 26:16 y, 15:0 data).
  - WORDS_PER_SEG default, and Y_W = 11.
  - The same constants are to be used by the GMII receive parser.
- One natural sub-module: fifo2linebuf_seg, the segment tracker.
  - Compares key, holds cnt/mask and computes addr.
  - Outputs the write/err/line_done decisions.
  - The top keeps the pop logic and output registers.

Test Plan:
- 600 words x=0 y=5 data=i, then 600 words x=1 y=5, FIFO never empty:
  - buf_addr 0..1199 contiguous, bank 1, wdata matches.
  - line_done exactly once, with line_y=5, one cycle after addr 1199.
  - err_cnt 0.
- 300 words x=0 y=6, then 600 words x=1 y=6:
  - err_cnt=1; second segment at addr 600..1199.
  - No line_done.
  - Then 600 words x=0 y=6 gives line_done with line_y=6.
- 601 words x=0 y=7:
  - 600 writes; the 601st is not written.
  - err_cnt=1.
- Random fifo_empty gaps and hold toggling across a full line y=8:
  - fifo_rd_en never high while empty or hold.
  - Addresses contiguous with no gaps or duplicates.
  - line_done once.
- Word with bit28=1 mid-segment:
  - No write, err_cnt+1; the segment continues with unchanged cnt.
- Assert sys_rst_n low after 200 words of x=0 y=9, then send a full line y=9:
  - All outputs 0 during reset, with no write from the pre-reset pop.
  - After release, normal addresses 0..1199 and line_done with line_y=9.
